// File: rtl/pulse_sync_multi.sv
// Multi-channel toggle-handshake pulse synchroniser (clk_in -> clk_out) with per-channel event backlog.
// Pulse appears SYNC_STAGES+1 clk_out edges after launch; excess events queue in a saturating counter.
module pulse_sync_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            clk_out,
  input  logic [N_CH-1:0] pulse_in,
  input  logic [N_CH-1:0] ovf_clr,
  output logic [N_CH-1:0] pulse_out,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] overflow
);

  localparam logic [CNT_W-1:0] P_MAX = '1;
  localparam logic [CNT_W-1:0] P_ONE = CNT_W'(1);

  // Reset carried into clk_out; held long enough that ACK=0 propagates back before release.
  logic [SYNC_STAGES-1:0] rst_sync;
  logic                   rst_o;

  always_ff @(posedge clk_out) begin
    rst_sync <= {rst_sync[SYNC_STAGES-2:0], rst};
  end

  assign rst_o = rst_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic                   prev;
    logic                   req;
    logic                   ack;
    logic                   hist;
    logic [CNT_W-1:0]       p;
    logic [CNT_W-1:0]       p_nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   ack_s;
    logic                   req_s;
    logic                   ev;
    logic                   idle;
    logic                   launch;
    logic                   drop;
    logic                   ovf_r;
    logic                   busy_r;
    logic                   pulse_r;

    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign req_s = req_sync[SYNC_STAGES-1];

    always_comb begin
      ev     = (EDGE_MODE != 0) ? (pulse_in[i] & ~prev) : pulse_in[i];
      idle   = (req == ack_s);
      launch = idle && ((p != '0) || ev);
      drop   = ev && !launch && (p == P_MAX);
      p_nxt  = p;
      if (launch) begin
        // A launch with a simultaneous event leaves the backlog unchanged.
        if (!ev) p_nxt = p - P_ONE;
      end else if (ev && !drop) begin
        p_nxt = p + P_ONE;
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst) begin
        prev     <= 1'b0;
        req      <= 1'b0;
        ack_sync <= '0;
        p        <= '0;
        ovf_r    <= 1'b0;
        busy_r   <= 1'b0;
      end else begin
        prev     <= pulse_in[i];
        req      <= req ^ launch;
        ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
        p        <= p_nxt;
        if (drop)
          ovf_r <= 1'b1;
        else if (ovf_clr[i])
          ovf_r <= 1'b0;
        busy_r   <= !idle || (p != '0);
      end
    end

    always_ff @(posedge clk_out) begin
      if (rst_o) begin
        req_sync <= '0;
        hist     <= 1'b0;
        ack      <= 1'b0;
        pulse_r  <= 1'b0;
      end else begin
        req_sync <= {req_sync[SYNC_STAGES-2:0], req};
        hist     <= req_s;
        pulse_r  <= (req_s != hist);
        if (req_s != hist) ack <= req_s;
      end
    end

    assign overflow[i]  = ovf_r;
    assign busy[i]      = busy_r;
    assign pulse_out[i] = pulse_r;
  end

endmodule

// File: tb/tb_pulse_sync_multi.sv
// Directed bench for pulse_sync_multi: level-mode instance plus an edge-mode instance, varying clk_out rate.
module tb_pulse_sync_multi;

  logic       clk_in  = 1'b0;
  logic       clk_out = 1'b0;
  logic       rst     = 1'b1;
  logic [3:0] pulse_in = '0;
  logic [3:0] pulse_e  = '0;
  logic [3:0] ovf_clr  = '0;
  logic [3:0] po, busy, ovf;
  logic [3:0] po_e, busy_e, ovf_e;

  int half_out = 60;
  int total = 0;
  int bad   = 0;
  int pcnt[4]      = '{default: 0};
  int ecnt[4]      = '{default: 0};
  int last_edge[4] = '{default: 0};
  int wide      = 0;
  int out_edges = 0;
  logic [3:0] last_po   = '0;
  logic [3:0] last_po_e = '0;

  pulse_sync_multi #(.N_CH(4), .CNT_W(3), .SYNC_STAGES(2), .EDGE_MODE(0)) dut (
    .clk_in(clk_in), .rst(rst), .clk_out(clk_out), .pulse_in(pulse_in), .ovf_clr(ovf_clr),
    .pulse_out(po), .busy(busy), .overflow(ovf)
  );

  pulse_sync_multi #(.N_CH(4), .CNT_W(3), .SYNC_STAGES(2), .EDGE_MODE(1)) dut_e (
    .clk_in(clk_in), .rst(rst), .clk_out(clk_out), .pulse_in(pulse_e), .ovf_clr(ovf_clr),
    .pulse_out(po_e), .busy(busy_e), .overflow(ovf_e)
  );

  always #15 clk_in = ~clk_in;

  initial begin
    #7;
    forever #(half_out) clk_out = ~clk_out;
  end

  always @(posedge clk_out) out_edges++;

  always @(negedge clk_out) begin
    for (int c = 0; c < 4; c++) begin
      if (po[c]) begin
        pcnt[c]++;
        last_edge[c] = out_edges;
      end
      if (po_e[c]) ecnt[c]++;
      if ((po[c] && last_po[c]) || (po_e[c] && last_po_e[c])) wide++;
    end
    last_po   = po;
    last_po_e = po_e;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int snap[4];
  int esnap;
  int e0;
  int lat;
  int ev_cnt[4];

  initial begin
    // Reset: 40 clk_in cycles covers well over SYNC_STAGES+2 slow cycles.
    tick(40);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_pulse", int'(po), 0);
    rst = 1'b0;
    tick(5);

    // Single one-cycle event on channel 0, clk_out 4x slower.
    for (int c = 0; c < 4; c++) snap[c] = pcnt[c];
    pulse_in = 4'b0001;
    @(posedge clk_in);
    e0 = out_edges;
    #1;
    pulse_in = 4'b0000;
    tick(1);
    check("single_busy_hi", int'(busy[0]), 1);
    tick(60);
    lat = last_edge[0] - e0;
    check("single_cnt", pcnt[0] - snap[0], 1);
    check("single_lat_3_4", int'(lat >= 3 && lat <= 4), 1);
    check("single_busy_lo", int'(busy[0]), 0);
    check("single_others", (pcnt[1] - snap[1]) + (pcnt[2] - snap[2]) + (pcnt[3] - snap[3]), 0);

    // Five back-to-back events on channel 1.
    snap[1] = pcnt[1];
    pulse_in = 4'b0010;
    tick(5);
    pulse_in = 4'b0000;
    check("burst5_busy", int'(busy[1]), 1);
    tick(150);
    check("burst5_cnt", pcnt[1] - snap[1], 5);
    check("burst5_ovf", int'(ovf[1]), 0);
    check("burst5_busy_lo", int'(busy[1]), 0);

    // Ten events on channel 2: one launched, seven queued, two dropped.
    snap[2] = pcnt[2];
    pulse_in = 4'b0100;
    tick(10);
    pulse_in = 4'b0000;
    check("burst10_ovf_set", int'(ovf[2]), 1);
    tick(250);
    check("burst10_cnt", pcnt[2] - snap[2], 8);
    check("burst10_ovf_held", int'(ovf[2]), 1);
    ovf_clr = 4'b0100;
    tick(1);
    ovf_clr = 4'b0000;
    check("ovf_clr", int'(ovf[2]), 0);

    // Overflow set must win over a clear held at the same time.
    snap[2] = pcnt[2];
    ovf_clr = 4'b0100;
    pulse_in = 4'b0100;
    tick(9);
    pulse_in = 4'b0000;
    check("ovf_set_wins", int'(ovf[2]), 1);
    tick(1);
    check("ovf_clr_after", int'(ovf[2]), 0);
    ovf_clr = 4'b0000;
    tick(250);
    check("burst9_cnt", pcnt[2] - snap[2], 8);

    // Edge mode: a level held for 20 cycles is one event.
    esnap = ecnt[3];
    pulse_e = 4'b1000;
    tick(20);
    pulse_e = 4'b0000;
    tick(150);
    check("edge_cnt", ecnt[3] - esnap, 1);
    check("edge_ovf", int'(ovf_e[3]), 0);

    // Reset while channel 0 has a backlog of three.
    pulse_in = 4'b0001;
    tick(4);
    pulse_in = 4'b0000;
    check("pre_rst_busy", int'(busy[0]), 1);
    rst = 1'b1;
    tick(24);
    check("in_rst_busy", int'(busy), 0);
    rst = 1'b0;
    snap[0] = pcnt[0];
    tick(60);
    check("post_rst_cnt", pcnt[0] - snap[0], 0);
    check("post_rst_busy", int'(busy[0]), 0);
    pulse_in = 4'b0001;
    tick(1);
    pulse_in = 4'b0000;
    tick(60);
    check("post_rst_event", pcnt[0] - snap[0], 1);

    // Random traffic, clk_out 3x faster then 0.3x of clk_in.
    for (int pass = 0; pass < 2; pass++) begin
      half_out = (pass == 0) ? 5 : 50;
      tick(20);
      for (int c = 0; c < 4; c++) begin
        snap[c] = pcnt[c];
        ev_cnt[c] = 0;
      end
      for (int k = 0; k < 300; k++) begin
        for (int c = 0; c < 4; c++) begin
          pulse_in[c] = ($urandom_range(0, 31) == 0);
          if (pulse_in[c]) ev_cnt[c]++;
        end
        tick(1);
      end
      pulse_in = 4'b0000;
      tick(400);
      for (int c = 0; c < 4; c++)
        check($sformatf("rand%0d_ch%0d_cnt", pass, c), pcnt[c] - snap[c], ev_cnt[c]);
      check($sformatf("rand%0d_ovf", pass), int'(ovf), 0);
      check($sformatf("rand%0d_busy", pass), int'(busy), 0);
    end

    check("no_wide_pulse", wide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
